// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: round-robin sharing of one combinational 64-bit ALU
// between two requesters, with a registered, id-tagged response channel.
// Optional build macro SEQ_GRANT_COUNT_EN adds saturating per-requester
// grant counters (grant_cnt0 / grant_cnt1).
module alu_rr_sequencer #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned OPW   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero
`ifdef SEQ_GRANT_COUNT_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   ptr;        // requester favoured when both are valid
    logic   exec_id;    // requester whose operands are on the ALU
    logic   grant_any;
    logic   grant_id;

    // Round-robin grant; ready is only offered in IDLE, to one requester
    always_comb begin
        grant_any  = 1'b0;
        grant_id   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ptr;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
            req0_ready = grant_any && !grant_id;
            req1_ready = grant_any && grant_id;
        end
    end

    // Sequencer FSM: latch operands, drive the ALU one cycle, hold the response
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            exec_id    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        exec_id <= grant_id;
                        alu_op  <= grant_id ? req1_op : req0_op;
                        alu_a   <= grant_id ? req1_a  : req0_a;
                        alu_b   <= grant_id ? req1_b  : req0_b;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data  <= alu_out;
                    resp_zero  <= (alu_out == '0);
                    resp_id    <= exec_id;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        ptr        <= ~resp_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_GRANT_COUNT_EN
    localparam int unsigned CNTW = 16;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    // Saturating count of accepted operations per requester
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_valid && req0_ready && grant_cnt0 != CNT_MAX)
                grant_cnt0 <= grant_cnt0 + CNTW'(1);
            if (req1_valid && req1_ready && grant_cnt1 != CNT_MAX)
                grant_cnt1 <= grant_cnt1 + CNTW'(1);
        end
    end
`endif

endmodule
